// File: rtl/fpu_pkg.sv
// Shared FPU types: sticky-bit source select, result source, datapath widths.
package fpu_pkg;

    localparam int unsigned FRACTION_WIDTH  = 49;
    localparam int unsigned REMAINDER_WIDTH = 27;

    typedef enum logic [1:0] {
        STICKY_ADD_MUL  = 2'd0,
        STICKY_DIV_SQRT = 2'd1,
        STICKY_F2I      = 2'd2
    } sticky_sel_e;

    typedef enum logic {
        SRC_PIPE = 1'b0,
        SRC_ITER = 1'b1
    } src_e;

    function automatic sticky_sel_e pipe_sticky_sel(input logic is_f2i);
        return is_f2i ? STICKY_F2I : STICKY_ADD_MUL;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; grants only while enabled and remembers the last winner.
module rr_arbiter2
    import fpu_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b,
    output src_e last_grant
);

    src_e last_grant_q;
    src_e last_grant_d;

    always_comb begin
        gnt_a        = 1'b0;
        gnt_b        = 1'b0;
        last_grant_d = last_grant_q;
        if (enable) begin
            // On a tie the source that did not win last time goes first.
            if (req_a && (!req_b || last_grant_q == SRC_ITER)) begin
                gnt_a = 1'b1;
            end else if (req_b) begin
                gnt_b = 1'b1;
            end
        end
        if (gnt_a) begin
            last_grant_d = SRC_PIPE;
        end else if (gnt_b) begin
            last_grant_d = SRC_ITER;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= SRC_ITER;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;

endmodule

// File: rtl/rounding_unit_arbiter.sv
// Shares the rounding unit between the pipelined path and the div/sqrt unit
// through a single registered output stage with valid/ready backpressure.
module rounding_unit_arbiter
    import fpu_pkg::*;
#(
    parameter int unsigned TAG_WIDTH  = 4,
    parameter int unsigned FLAG_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       pa_valid,
    output logic                       pa_ready,
    input  logic                       pa_is_f2i,
    input  logic [FRACTION_WIDTH-1:0]  pa_fraction,
    input  logic [TAG_WIDTH-1:0]       pa_tag,
    input  logic [FLAG_WIDTH-1:0]      pa_flags,
    input  logic                       pb_valid,
    output logic                       pb_ready,
    input  logic [FRACTION_WIDTH-1:0]  pb_fraction,
    input  logic [REMAINDER_WIDTH-1:0] pb_remainder,
    input  logic [TAG_WIDTH-1:0]       pb_tag,
    input  logic [FLAG_WIDTH-1:0]      pb_flags,
    output logic                       ru_valid,
    input  logic                       ru_ready,
    output logic [1:0]                 ru_sticky_bit_select,
    output logic [FRACTION_WIDTH-1:0]  ru_fraction,
    output logic [REMAINDER_WIDTH-1:0] ru_remainder,
    output logic [TAG_WIDTH-1:0]       ru_tag,
    output logic [FLAG_WIDTH-1:0]      ru_flags,
    output logic                       ru_source
);

    logic                       valid_q,  valid_d;
    sticky_sel_e                sticky_q, sticky_d;
    logic [FRACTION_WIDTH-1:0]  frac_q,   frac_d;
    logic [REMAINDER_WIDTH-1:0] rem_q,    rem_d;
    logic [TAG_WIDTH-1:0]       tag_q,    tag_d;
    logic [FLAG_WIDTH-1:0]      flags_q,  flags_d;
    src_e                       src_q,    src_d;

    logic advance;
    logic xfer_en;
    logic gnt_a;
    logic gnt_b;
    src_e last_grant;

    assign advance = !valid_q || ru_ready;
    assign xfer_en = advance && !flush && !reset;

    rr_arbiter2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .enable     (xfer_en),
        .req_a      (pa_valid),
        .req_b      (pb_valid),
        .gnt_a      (gnt_a),
        .gnt_b      (gnt_b),
        .last_grant (last_grant)
    );

    assign pa_ready = gnt_a;
    assign pb_ready = gnt_b;

    // Payload mux into the output stage; an idle advance drops valid but keeps data.
    always_comb begin
        valid_d  = valid_q;
        sticky_d = sticky_q;
        frac_d   = frac_q;
        rem_d    = rem_q;
        tag_d    = tag_q;
        flags_d  = flags_q;
        src_d    = src_q;
        if (flush) begin
            valid_d  = 1'b0;
            sticky_d = STICKY_ADD_MUL;
            frac_d   = '0;
            rem_d    = '0;
            tag_d    = '0;
            flags_d  = '0;
            src_d    = SRC_PIPE;
        end else if (gnt_a) begin
            valid_d  = 1'b1;
            sticky_d = pipe_sticky_sel(pa_is_f2i);
            frac_d   = pa_fraction;
            rem_d    = '0;
            tag_d    = pa_tag;
            flags_d  = pa_flags;
            src_d    = SRC_PIPE;
        end else if (gnt_b) begin
            valid_d  = 1'b1;
            sticky_d = STICKY_DIV_SQRT;
            frac_d   = pb_fraction;
            rem_d    = pb_remainder;
            tag_d    = pb_tag;
            flags_d  = pb_flags;
            src_d    = SRC_ITER;
        end else if (advance) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            sticky_q <= STICKY_ADD_MUL;
            frac_q   <= '0;
            rem_q    <= '0;
            tag_q    <= '0;
            flags_q  <= '0;
            src_q    <= SRC_PIPE;
        end else begin
            valid_q  <= valid_d;
            sticky_q <= sticky_d;
            frac_q   <= frac_d;
            rem_q    <= rem_d;
            tag_q    <= tag_d;
            flags_q  <= flags_d;
            src_q    <= src_d;
        end
    end

    assign ru_valid             = valid_q;
    assign ru_sticky_bit_select = 2'(sticky_q);
    assign ru_fraction          = frac_q;
    assign ru_remainder         = rem_q;
    assign ru_tag               = tag_q;
    assign ru_flags             = flags_q;
    assign ru_source            = 1'(src_q);

    logic unused_last_grant;
    assign unused_last_grant = 1'(last_grant);

endmodule

// File: tb/tb_rounding_unit_arbiter.sv
// Directed plus randomized bench for rounding_unit_arbiter against a transaction-level model.
`timescale 1ns/1ps
module tb_rounding_unit_arbiter;

    localparam int unsigned TW = 4;
    localparam int unsigned FW = 5;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        pa_valid, pa_ready, pa_is_f2i;
    logic [48:0] pa_fraction;
    logic [TW-1:0] pa_tag;
    logic [FW-1:0] pa_flags;
    logic        pb_valid, pb_ready;
    logic [48:0] pb_fraction;
    logic [26:0] pb_remainder;
    logic [TW-1:0] pb_tag;
    logic [FW-1:0] pb_flags;
    logic        ru_valid, ru_ready;
    logic [1:0]  ru_sticky_bit_select;
    logic [48:0] ru_fraction;
    logic [26:0] ru_remainder;
    logic [TW-1:0] ru_tag;
    logic [FW-1:0] ru_flags;
    logic        ru_source;

    always #5 clk = ~clk;

    rounding_unit_arbiter #(.TAG_WIDTH(TW), .FLAG_WIDTH(FW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .pa_valid(pa_valid), .pa_ready(pa_ready), .pa_is_f2i(pa_is_f2i),
        .pa_fraction(pa_fraction), .pa_tag(pa_tag), .pa_flags(pa_flags),
        .pb_valid(pb_valid), .pb_ready(pb_ready), .pb_fraction(pb_fraction),
        .pb_remainder(pb_remainder), .pb_tag(pb_tag), .pb_flags(pb_flags),
        .ru_valid(ru_valid), .ru_ready(ru_ready),
        .ru_sticky_bit_select(ru_sticky_bit_select), .ru_fraction(ru_fraction),
        .ru_remainder(ru_remainder), .ru_tag(ru_tag), .ru_flags(ru_flags),
        .ru_source(ru_source)
    );

    int compared = 0;
    int mismatched = 0;

    // Model: contents of the output stage plus who won last (1 = path B).
    bit          m_valid, m_last;
    logic [1:0]  m_sel;
    logic [48:0] m_frac;
    logic [26:0] m_rem;
    logic [TW-1:0] m_tag;
    logic [FW-1:0] m_flags;
    bit          m_src;
    bit          e_pa, e_pb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        m_valid = 0; m_sel = 0; m_frac = 0; m_rem = 0; m_tag = 0; m_flags = 0; m_src = 0;
    endtask

    // Who the model says is accepted this cycle, from the arbitration rules.
    task automatic predict();
        bit room;
        room = (!m_valid || ru_ready) && !flush && !reset;
        e_pa = 0; e_pb = 0;
        if (room && pa_valid && pb_valid) begin
            if (m_last) e_pa = 1; else e_pb = 1;
        end else if (room && pa_valid) e_pa = 1;
        else if (room && pb_valid) e_pb = 1;
    endtask

    task automatic update_model();
        bit room;
        room = !m_valid || ru_ready;
        if (reset) begin
            clear_model(); m_last = 1;
        end else if (flush) begin
            clear_model();
        end else if (e_pa) begin
            m_valid = 1; m_sel = pa_is_f2i ? 2'd2 : 2'd0; m_frac = pa_fraction; m_rem = 0;
            m_tag = pa_tag; m_flags = pa_flags; m_src = 0; m_last = 0;
        end else if (e_pb) begin
            m_valid = 1; m_sel = 2'd1; m_frac = pb_fraction; m_rem = pb_remainder;
            m_tag = pb_tag; m_flags = pb_flags; m_src = 1; m_last = 1;
        end else if (room) begin
            m_valid = 0;
        end
    endtask

    task automatic check_outputs();
        chk("ru_valid", 64'(ru_valid), 64'(m_valid));
        chk("ru_sticky", 64'(ru_sticky_bit_select), 64'(m_sel));
        chk("ru_fraction", 64'(ru_fraction), 64'(m_frac));
        chk("ru_remainder", 64'(ru_remainder), 64'(m_rem));
        chk("ru_tag", 64'(ru_tag), 64'(m_tag));
        chk("ru_flags", 64'(ru_flags), 64'(m_flags));
        chk("ru_source", 64'(ru_source), 64'(m_src));
    endtask

    // Called just after an edge with new inputs applied; checks readys then the registered result.
    task automatic tick();
        #1;
        predict();
        chk("pa_ready", 64'(pa_ready), 64'(e_pa));
        chk("pb_ready", 64'(pb_ready), 64'(e_pb));
        chk("one_hot_ready", 64'(pa_ready & pb_ready), 64'(0));
        @(posedge clk);
        update_model();
        #1;
        check_outputs();
    endtask

    initial begin
        logic [48:0] frac_f2i;
        logic [1:0]  hold_sel;
        logic [48:0] hold_frac;
        bit          last_before;

        frac_f2i = 49'h1_0000_0000_7FFF;
        clear_model(); m_last = 1;
        reset = 1; flush = 0; ru_ready = 1;
        pa_valid = 1; pa_is_f2i = 0; pa_fraction = 49'h123; pa_tag = 4'h1; pa_flags = 5'h3;
        pb_valid = 0; pb_fraction = 0; pb_remainder = 0; pb_tag = 0; pb_flags = 0;
        @(posedge clk); #1;

        // Reset held for two cycles with path A requesting.
        tick();
        tick();
        chk("reset_ru_valid", 64'(ru_valid), 64'(0));
        chk("reset_pa_ready", 64'(pa_ready), 64'(0));

        reset = 0;
        tick();
        chk("first_ru_valid", 64'(ru_valid), 64'(1));
        chk("first_ru_source", 64'(ru_source), 64'(0));

        // Float-to-int result selects the f2i sticky rule and zero remainder.
        pa_is_f2i = 1; pa_fraction = frac_f2i; pa_tag = 4'h2;
        tick();
        chk("f2i_sticky", 64'(ru_sticky_bit_select), 64'(2));
        chk("f2i_fraction", 64'(ru_fraction), 64'(frac_f2i));
        chk("f2i_remainder", 64'(ru_remainder), 64'(0));

        // Div/sqrt result held while the rounder stalls.
        pa_valid = 0; pa_is_f2i = 0;
        pb_valid = 1; pb_remainder = 27'h1; pb_fraction = 49'hABCDE; pb_tag = 4'h9;
        tick();
        chk("b_sticky", 64'(ru_sticky_bit_select), 64'(1));
        hold_sel = ru_sticky_bit_select; hold_frac = ru_fraction;
        ru_ready = 0; pb_tag = 4'hA; pb_remainder = 27'h5;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pb_ready", 64'(pb_ready), 64'(0));
            chk("stall_valid", 64'(ru_valid), 64'(1));
            chk("stall_rem", 64'(ru_remainder), 64'(1));
            chk("stall_frac", 64'(ru_fraction), 64'(hold_frac));
            chk("stall_sel", 64'(ru_sticky_bit_select), 64'(hold_sel));
        end
        ru_ready = 1;
        tick();
        chk("after_stall_tag", 64'(ru_tag), 64'(4'hA));
        pb_valid = 0;
        tick();

        // Both sources continuously valid: strict alternation starting with A.
        pa_valid = 1; pb_valid = 1;
        for (int i = 0; i < 6; i++) begin
            pa_tag = TW'(i / 2); pb_tag = TW'(8 + i / 2);
            tick();
            chk("alt_source", 64'(ru_source), 64'(i % 2));
            chk("alt_tag", 64'(ru_tag), 64'((i % 2 == 0) ? i / 2 : 8 + i / 2));
        end

        // Back-to-back A with the rounder toggling ready.
        pb_valid = 0;
        for (int i = 0; i < 6; i++) begin
            ru_ready = (i % 3 != 1);
            pa_tag = TW'(i + 3);
            tick();
        end
        ru_ready = 1;

        // Flush with both valid and a held result; arbitration resumes from the old winner.
        pa_valid = 1; pb_valid = 1; ru_ready = 0;
        tick();
        last_before = m_last;
        flush = 1;
        tick();
        chk("flush_valid", 64'(ru_valid), 64'(0));
        flush = 0; ru_ready = 1;
        tick();
        chk("post_flush_src", 64'(ru_source), 64'(!last_before));

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 49) == 0);
            flush       = ($urandom_range(0, 19) == 0);
            ru_ready    = ($urandom_range(0, 3) != 0);
            pa_valid    = 1'($urandom);
            pb_valid    = 1'($urandom);
            pa_is_f2i   = 1'($urandom);
            pa_fraction = 49'({$urandom(), $urandom()});
            pb_fraction = 49'({$urandom(), $urandom()});
            pb_remainder = 27'($urandom);
            pa_tag      = TW'($urandom);
            pb_tag      = TW'($urandom);
            pa_flags    = FW'($urandom);
            pb_flags    = FW'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
